// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
//
// Contents:
//   state_t : responder FSM states (IDLE, LAT, BURST)
//   op_t    : latched transaction type (READ, WRITE)
//   BEAT_W, LINE_W, BEATS, OFFSET_BITS, BEAT_IDX_W, LAT_W : geometry constants
package burst_mem_pkg;

  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_IDX_W  = 2;
  localparam int LAT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LAT   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage : burst_mem_pkg

// File: rtl/burst_mem_array.sv
// Backing store of 2**IDX_W lines, each 256 bits, organised as 4 beats of 64.
// Contents are not affected by reset.
//
// Ports:
//   clk   : clock
//   idx   : line index shared by the read and write ports
//   beat  : beat select (0 = bits [63:0] .. 3 = bits [255:192])
//   we    : beat write enable, commits wdata at the rising edge
//   wdata : 64-bit write beat
//   rdata : 64-bit combinational read of store[idx] beat 'beat'
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      idx,
  input  logic [BEAT_IDX_W-1:0] beat,
  input  logic                  we,
  input  logic [BEAT_W-1:0]     wdata,
  output logic [BEAT_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  // Packed beats per line: beat 0 occupies the low 64 bits of the line.
  logic [BEATS-1:0][BEAT_W-1:0] mem_r [DEPTH];

  // Beat-granular write; each beat commits independently of the others.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx][beat] <= wdata;
    end
  end

  assign rdata = mem_r[idx][beat];

endmodule : burst_mem_array

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit, 4-beat line burst protocol.
// Accepts one line read or write per request, waits LATENCY cycles from
// accept, then strobes resp_o for 4 consecutive beats.
//
// Optional feature macro: BURST_MEM_PROTO_CHK_EN adds a sticky proto_err
// output flagging request drops, simultaneous read/write requests in IDLE,
// and address changes while a transaction is in flight.
//
// Ports:
//   clk       : clock
//   reset     : synchronous active-high reset (store contents are kept)
//   address_i : byte address; index = address_i[5 +: IDX_W], other bits ignored
//   read_i    : read request, held until the 4th beat completes
//   write_i   : write request, held until the 4th beat completes
//   burst_i   : write beat data, sampled on each write beat
//   burst_o   : read beat data, valid while resp_o=1 on a read
//   resp_o    : beat strobe
//   proto_err : (BURST_MEM_PROTO_CHK_EN only) sticky protocol violation flag
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o
`ifdef BURST_MEM_PROTO_CHK_EN
  ,
  output logic              proto_err
`endif
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
  // With LATENCY=1 the first beat follows accept directly, so LAT is skipped.
  localparam bit SKIP_LAT = (LATENCY == 1);

  state_t                state_r, state_s;
  op_t                   op_r, op_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [LAT_W-1:0]      lat_cnt_r, lat_cnt_s;
  logic [BEAT_IDX_W-1:0] beat_r, beat_s;

  logic                  req_live_s;
  logic                  beat_active_s;
  logic                  we_s;
  logic [BEAT_W-1:0]     rd_data_s;

  // Only the index field of the address selects a line; the rest aliases.
  logic addr_unused_s;
  assign addr_unused_s = ^{address_i[31:OFFSET_BITS+IDX_W], address_i[OFFSET_BITS-1:0]};

  // The request line matching the latched op must stay high for the whole transaction.
  assign req_live_s = (op_r == OP_READ) ? read_i : write_i;

  // A beat is issued only while the request is still held, so a drop
  // suppresses both the strobe and the write in the cycle it is seen.
  assign beat_active_s = (state_r == ST_BURST) && req_live_s && !reset;
  assign we_s          = beat_active_s && (op_r == OP_WRITE);
  assign resp_o        = beat_active_s;
  assign burst_o       = (beat_active_s && (op_r == OP_READ)) ? rd_data_s : {BEAT_W{1'b0}};

  // Next-state logic: accept in IDLE, count latency in LAT, step beats in BURST.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    idx_s     = idx_r;
    lat_cnt_s = lat_cnt_r;
    beat_s    = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (read_i || write_i) begin
          // Read wins when both requests are high.
          op_s      = read_i ? OP_READ : OP_WRITE;
          idx_s     = address_i[OFFSET_BITS +: IDX_W];
          lat_cnt_s = LAT_INIT;
          beat_s    = {BEAT_IDX_W{1'b0}};
          state_s   = SKIP_LAT ? ST_BURST : ST_LAT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAT: begin
        if (!req_live_s) begin
          state_s   = ST_IDLE;
          lat_cnt_s = {LAT_W{1'b0}};
        end else if (lat_cnt_r <= LAT_W'(1)) begin
          // Counter reaches zero on this edge: first beat is next cycle.
          state_s   = ST_BURST;
          lat_cnt_s = {LAT_W{1'b0}};
          beat_s    = {BEAT_IDX_W{1'b0}};
        end else begin
          lat_cnt_s = lat_cnt_r - LAT_W'(1);
        end
      end
      ST_BURST: begin
        if (!req_live_s) begin
          state_s = ST_IDLE;
          beat_s  = {BEAT_IDX_W{1'b0}};
        end else if (beat_r == BEAT_IDX_W'(BEATS - 1)) begin
          state_s = ST_IDLE;
          beat_s  = {BEAT_IDX_W{1'b0}};
        end else begin
          beat_s = beat_r + BEAT_IDX_W'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        lat_cnt_s = {LAT_W{1'b0}};
        beat_s    = {BEAT_IDX_W{1'b0}};
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_READ;
      idx_r     <= {IDX_W{1'b0}};
      lat_cnt_r <= {LAT_W{1'b0}};
      beat_r    <= {BEAT_IDX_W{1'b0}};
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      idx_r     <= idx_s;
      lat_cnt_r <= lat_cnt_s;
      beat_r    <= beat_s;
    end
  end

  burst_mem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .idx   (idx_r),
    .beat  (beat_r),
    .we    (we_s),
    .wdata (burst_i),
    .rdata (rd_data_s)
  );

`ifdef BURST_MEM_PROTO_CHK_EN
  logic [31:0] addr_r;
  logic        proto_err_r;
  logic        viol_s;

  // Violation detect: dual request at accept, or drop/address change in flight.
  always_comb begin
    viol_s = 1'b0;
    case (state_r)
      ST_IDLE:  viol_s = read_i && write_i;
      ST_LAT,
      ST_BURST: viol_s = !req_live_s || (address_i != addr_r);
      default:  viol_s = 1'b0;
    endcase
  end

  // Latch the accepted address and accumulate the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= 32'h0000_0000;
      proto_err_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && (read_i || write_i)) begin
        addr_r <= address_i;
      end
      proto_err_r <= proto_err_r | viol_s;
    end
  end

  assign proto_err = proto_err_r;
`endif

endmodule : burst_mem_responder
